// File: rtl/fetch_pc_ctrl_pkg.sv
// rtl/fetch_pc_ctrl_pkg.sv - shared constants, types and helpers for the fetch PC controller
// Purpose: BHT reset value, architectural register numbers used for call/return
//          detection, prediction source type and the 2-bit saturating update.
// Ports:   none (package).
package fetch_pc_ctrl_pkg;

  localparam logic [1:0] BHT_RESET = 2'b01;  // weakly not-taken
  localparam logic [4:0] REG_RA    = 5'd1;
  localparam logic [4:0] REG_ZERO  = 5'd0;

  // Where the predicted next PC comes from.
  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,  // pc + 4
    SRC_REL = 2'd1,  // pc + imme (jal, taken branch)
    SRC_RAS = 2'd2   // RAS top + imme (return)
  } pred_src_e;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// rtl/fetch_pc_ctrl_if.sv - decode, EX-resolution and prediction signals of the fetch stage
// Purpose: bundles everything except clk/rst_n between the pipeline and fetch_pc_ctrl.
// Ports:   master - pipeline side (drives decode/EX inputs, observes pc/prediction/flush)
//          slave  - fetch_pc_ctrl side
interface fetch_pc_ctrl_if;
  logic        stall_if;
  logic        jal;
  logic        jalr;
  logic        B_type;
  logic [4:0]  Rd;
  logic [4:0]  Rs1;
  logic [31:0] imme;
  logic        ex_br_valid;
  logic [31:0] ex_br_pc;
  logic        ex_br_taken;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;

  modport master (
    output stall_if, jal, jalr, B_type, Rd, Rs1, imme,
    output ex_br_valid, ex_br_pc, ex_br_taken, ex_redirect, ex_target,
    input  pc, pred_taken, pred_target, flush
  );

  modport slave (
    input  stall_if, jal, jalr, B_type, Rd, Rs1, imme,
    input  ex_br_valid, ex_br_pc, ex_br_taken, ex_redirect, ex_target,
    output pc, pred_taken, pred_target, flush
  );
endinterface

// File: rtl/fetch_pc_ctrl_bht.sv
// rtl/fetch_pc_ctrl_bht.sv - 2-bit saturating-counter branch history table
// Purpose: counter array with one combinational read port and one update port.
// Ports:   clk, rst_n           - clock, async active-low reset (all counters to BHT_RESET)
//          rd_idx / rd_ctr      - read index and current counter value
//          upd_valid, upd_idx,
//          upd_taken            - saturating increment/decrement of one counter
module bht_2bit
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0] ctr [ENTRIES];

  // Read straight from the registers, so a same-cycle update to the same
  // entry is seen only from the next cycle on.
  assign rd_ctr = ctr[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= BHT_RESET;
      end
    end else if (upd_valid) begin
      ctr[upd_idx] <= sat_update(ctr[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - fetch PC register with BHT/RAS next-address prediction
// Purpose: holds the fetch PC, predicts the next fetch address from the mini-decoder
//          outputs, keeps a return-address stack and applies EX redirects.
// Ports:   clk, rst_n - clock, async active-low reset
//          bus        - fetch_pc_ctrl_if.slave (decode, EX resolution, pc, prediction, flush)
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 4,
  parameter int          RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_pc_ctrl_if.slave  bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [31:0]      pc_q;
  logic [31:0]      pc4;
  logic [31:0]      pred_target;
  logic             pred_taken;
  pred_src_e        src;
  logic [1:0]       bht_ctr;

  logic [31:0]      ras [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ras_ptr_m1;
  logic [CNT_W-1:0] ras_cnt;
  logic [31:0]      ras_top;
  logic             ras_has;
  logic             is_call;
  logic             is_ret;
  logic             ras_en;
  logic             do_push;
  logic             do_pop;

  // Only the index bits of the branch PC and the counter's direction bit are used.
  logic             unused_bits;
  assign unused_bits = ^{bus.ex_br_pc[31:BHT_IDX_W+2], bus.ex_br_pc[1:0], bht_ctr[0]};

  bht_2bit #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (pc_q[BHT_IDX_W+1:2]),
    .rd_ctr    (bht_ctr),
    .upd_valid (bus.ex_br_valid),
    .upd_idx   (bus.ex_br_pc[BHT_IDX_W+1:2]),
    .upd_taken (bus.ex_br_taken)
  );

  assign pc4        = pc_q + 32'd4;
  assign is_call    = (bus.jal || bus.jalr) && (bus.Rd == REG_RA);
  assign is_ret     = bus.jalr && (bus.Rs1 == REG_RA) && (bus.Rd == REG_ZERO);
  assign ras_has    = (ras_cnt != '0);
  assign ras_ptr_m1 = ras_ptr - PTR_W'(1);
  assign ras_top    = ras[ras_ptr_m1];

  always_comb begin
    src = SRC_SEQ;
    if (bus.jal) begin
      src = SRC_REL;
    end else if (bus.B_type) begin
      src = bht_ctr[1] ? SRC_REL : SRC_SEQ;
    end else if (is_ret && ras_has) begin
      src = SRC_RAS;
    end
  end

  always_comb begin
    pred_taken  = (src != SRC_SEQ);
    pred_target = pc4;
    case (src)
      SRC_REL: pred_target = pc_q + bus.imme;
      SRC_RAS: pred_target = (ras_top + bus.imme) & ~32'd1;
      default: pred_target = pc4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (bus.ex_redirect) begin
      pc_q <= bus.ex_target;
    end else if (!bus.stall_if) begin
      pc_q <= pred_target;
    end
  end

  // The RAS follows only the instruction that actually advances fetch; it is
  // not repaired on redirect, EX corrects any resulting misprediction.
  assign ras_en  = !bus.ex_redirect && !bus.stall_if;
  assign do_push = ras_en && is_call;
  assign do_pop  = ras_en && is_ret && ras_has && !is_call;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (do_push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_cnt != CNT_MAX) begin
        ras_cnt <= ras_cnt + CNT_W'(1);
      end
    end else if (do_pop) begin
      ras_ptr <= ras_ptr_m1;
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end

  // Entries are don't-care after reset; when full, the push wraps onto the oldest.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras[ras_ptr] <= pc4;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_target;
  assign bus.flush       = bus.ex_redirect;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - scoreboard bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] M8     = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if bus();

  fetch_pc_ctrl #(
    .RESET_PC  (RST_PC),
    .BHT_IDX_W (4),
    .RAS_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        fl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.nm, "pc",          bus.pc,                   e.pc);
      chk(e.nm, "pred_taken",  {31'd0, bus.pred_taken},  {31'd0, e.tk});
      chk(e.nm, "pred_target", bus.pred_target,          e.tgt);
      chk(e.nm, "flush",       {31'd0, bus.flush},       {31'd0, e.fl});
    end
  end

  task automatic clr();
    bus.stall_if    = 1'b0;
    bus.jal         = 1'b0;
    bus.jalr        = 1'b0;
    bus.B_type      = 1'b0;
    bus.Rd          = 5'd0;
    bus.Rs1         = 5'd0;
    bus.imme        = 32'd0;
    bus.ex_br_valid = 1'b0;
    bus.ex_br_pc    = 32'd0;
    bus.ex_br_taken = 1'b0;
    bus.ex_redirect = 1'b0;
    bus.ex_target   = 32'd0;
  endtask

  task automatic jal_i(input logic [4:0] rd, input logic [31:0] im);
    bus.jal = 1'b1; bus.Rd = rd; bus.imme = im;
  endtask

  task automatic jalr_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] im);
    bus.jalr = 1'b1; bus.Rd = rd; bus.Rs1 = rs1; bus.imme = im;
  endtask

  task automatic br_i(input logic [31:0] im);
    bus.B_type = 1'b1; bus.imme = im;
  endtask

  task automatic upd(input logic [31:0] p, input logic t);
    bus.ex_br_valid = 1'b1; bus.ex_br_pc = p; bus.ex_br_taken = t;
  endtask

  task automatic redir(input logic [31:0] t);
    bus.ex_redirect = 1'b1; bus.ex_target = t;
  endtask

  // Queue the expected outputs for this cycle, then advance one clock.
  task automatic cyc(input string nm, input logic [31:0] p, input logic tk,
                     input logic [31:0] tgt, input logic fl);
    exp_t e;
    e.nm = nm; e.pc = p; e.tk = tk; e.tgt = tgt; e.fl = fl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", 32'h100, 0, 32'h104, 0);
    rst_n = 1'b1;

    cyc("seq0", 32'h100, 0, 32'h104, 0);
    cyc("seq1", 32'h104, 0, 32'h108, 0);
    cyc("seq2", 32'h108, 0, 32'h10c, 0);
    rst_n = 1'b0;
    cyc("async_rst", 32'h100, 0, 32'h104, 0);
    rst_n = 1'b1;

    jal_i(5'd0, 32'h40);           cyc("jal",       32'h100, 1, 32'h140, 0);
    redir(32'h200);                cyc("redir_200", 32'h140, 0, 32'h144, 1);

    br_i(M8);                      cyc("br_cold",   32'h200, 0, 32'h204, 0);
    upd(32'h200, 1);               cyc("upd_t1",    32'h204, 0, 32'h208, 0);
    upd(32'h200, 1);               cyc("upd_t2",    32'h208, 0, 32'h20c, 0);
    upd(32'h200, 1);               cyc("upd_t3",    32'h20c, 0, 32'h210, 0);
    redir(32'h200);                cyc("redir_b",   32'h210, 0, 32'h214, 1);
    br_i(M8);                      cyc("br_taken",  32'h200, 1, 32'h1f8, 0);
    upd(32'h200, 0);               cyc("upd_n1",    32'h1f8, 0, 32'h1fc, 0);
                                   cyc("seq_1fc",   32'h1fc, 0, 32'h200, 0);
    br_i(M8); upd(32'h200, 0);     cyc("br_rbw",    32'h200, 1, 32'h1f8, 0);
    upd(32'h200, 0);               cyc("upd_n3",    32'h1f8, 0, 32'h1fc, 0);
    upd(32'h200, 0);               cyc("upd_n4",    32'h1fc, 0, 32'h200, 0);
    br_i(M8); upd(32'h200, 1);     cyc("br_floor",  32'h200, 0, 32'h204, 0);

    redir(32'h300);                cyc("redir_300", 32'h204, 0, 32'h208, 1);
    jal_i(5'd1, 32'h100);          cyc("call",      32'h300, 1, 32'h400, 0);
    jalr_i(5'd0, 5'd1, 32'h0);     cyc("ret",       32'h400, 1, 32'h304, 0);
    jalr_i(5'd0, 5'd1, 32'h0);     cyc("ret_empty", 32'h304, 0, 32'h308, 0);

    jal_i(5'd1, 32'h100);          cyc("c1",        32'h308, 1, 32'h408, 0);
    jal_i(5'd1, 32'h100);          cyc("c2",        32'h408, 1, 32'h508, 0);
    jal_i(5'd1, 32'h100);          cyc("c3",        32'h508, 1, 32'h608, 0);
    jal_i(5'd1, 32'h100);          cyc("c4",        32'h608, 1, 32'h708, 0);
    jal_i(5'd1, 32'h100);          cyc("c5",        32'h708, 1, 32'h808, 0);
    jalr_i(5'd0, 5'd1, 32'h0);     cyc("r1",        32'h808, 1, 32'h70c, 0);
    jalr_i(5'd0, 5'd1, 32'h0);     cyc("r2",        32'h70c, 1, 32'h60c, 0);
    jalr_i(5'd0, 5'd1, 32'h0);     cyc("r3",        32'h60c, 1, 32'h50c, 0);
    jalr_i(5'd0, 5'd1, 32'h0);     cyc("r4",        32'h50c, 1, 32'h40c, 0);
    jalr_i(5'd0, 5'd1, 32'h0);     cyc("r5_empty",  32'h40c, 0, 32'h410, 0);

    jal_i(5'd1, 32'h10);           cyc("pre_call",  32'h410, 1, 32'h420, 0);
    redir(32'h500); bus.stall_if = 1'b1; jal_i(5'd1, 32'h40);
                                   cyc("same_cycle", 32'h420, 1, 32'h460, 1);
    bus.stall_if = 1'b1; jal_i(5'd1, 32'h20);
                                   cyc("stall",     32'h500, 1, 32'h520, 0);
    jalr_i(5'd0, 5'd1, 32'h0);     cyc("ret_after", 32'h500, 1, 32'h414, 0);
    jalr_i(5'd0, 5'd1, 32'h0);     cyc("ret_after_empty", 32'h414, 0, 32'h418, 0);
    jalr_i(5'd0, 5'd5, 32'h0);     cyc("jalr_other", 32'h418, 0, 32'h41c, 0);
    jalr_i(5'd1, 5'd1, 32'h0);     cyc("jalr_call", 32'h41c, 0, 32'h420, 0);
    jalr_i(5'd0, 5'd1, 32'h5);     cyc("ret_imm",   32'h420, 1, 32'h424, 0);
                                   cyc("final",     32'h424, 0, 32'h428, 0);

    @(negedge clk);
    #1;
    chk("drain", "queue_size", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Owns the fetch-stage PC register and picks the next fetch address every cycle.
- Takes the fetch-stage mini-decoder outputs for the instruction at the current PC, predicts the next address, and predicts the return address for jalr.
- Prediction uses a 2-bit-counter branch history table (BHT) and a small return-address stack (RAS).
- The EX stage updates the BHT and redirects fetch on a mispredict.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- BHT_IDX_W, 4, log2 of BHT entries (16 entries); index is pc[BHT_IDX_W+1:2].
- RAS_DEPTH, 4, RAS entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_if  in  1  hold the PC (hazard or memory wait).
- jal  in  1  decoded jal at the current PC.
- jalr  in  1  decoded jalr at the current PC.
- B_type  in  1  decoded conditional branch at the current PC.
- Rd  in  5  decoded rd.
- Rs1  in  5  decoded rs1.
- imme  in  32  decoded jal, jalr or branch immediate.
- ex_br_valid  in  1  EX resolved a conditional branch this cycle.
- ex_br_pc  in  32  PC of that branch.
- ex_br_taken  in  1  actual outcome of that branch.
- ex_redirect  in  1  mispredict or jalr target mismatch; flush and refetch.
- ex_target  in  32  correct address for the redirect.
- pc  out  32  current fetch PC, registered.
- pred_taken  out  1  prediction for the instruction at pc (combinational; the IF/ID register carries it to EX).
- pred_target  out  32  predicted next PC (combinational).
- flush  out  1  kill the IF/ID and ID/EX contents; equals ex_redirect.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC.
  - All BHT counters = 2'b01 (weakly not-taken).
  - RAS pointer=0, count=0; entries are don't-care.
- Prediction, combinational, with pc4 = pc+4 (32-bit, wraps):
  - jal: pred_taken=1, pred_target=pc+imme.
  - B_type: pred_taken=BHT[pc idx][1]. Target is pc+imme when taken, otherwise pc4.
  - jalr with Rs1==1, Rd==0 (return) and count>0: pred_taken=1, pred_target=RAS top + imme, bit 0 cleared.
  - jalr otherwise, or RAS empty: pred_taken=0, pred_target=pc4.
  - Anything else: pred_taken=0, pred_target=pc4.
- PC update at each rising edge, in priority order:
  1. ex_redirect: pc<=ex_target.
  2. stall_if: pc holds.
  3. Otherwise pc<=pred_target.
- BHT update:
  - On ex_br_valid, the counter at ex_br_pc idx saturating-increments if ex_br_taken, otherwise saturating-decrements (00 floor, 11 ceiling).
  - Updates happen independent of stall_if and ex_redirect.
  - If the update index equals the prediction index in the same cycle, the prediction uses the pre-update value (read-before-write).
- RAS:
  - Acts only in cycles with !ex_redirect && !stall_if.
  - Push: jal or jalr with Rd==1 writes pc4 at the pointer, pointer+1 mod RAS_DEPTH, count saturates at RAS_DEPTH. When full, the oldest entry is overwritten.
  - Pop: return-jalr with count>0; pointer-1 mod RAS_DEPTH, count-1.
  - Pop when empty: no state change.
  - Push and pop never coincide: a jalr with Rd==1 pushes only.
  - The RAS is not repaired on redirect; a misprediction there is corrected by EX.
- flush=ex_redirect, same cycle, no latency.
- Reset mid-operation: every state returns to its reset value immediately; the first post-reset fetch is RESET_PC.

Decomposition:
- Shared package (the existing define include): BHT reset value 2'b01, the ra register number 5'd1, the zero register 5'd0.
- One sub-module, bht_2bit: counter array plus saturating update logic, with a read port and an update port.
- The RAS stays inline.

Test Plan:
- Reset with RESET_PC=32'h100, no instructions decoded → pc=0x100, then 0x104, 0x108 on consecutive cycles. Assert rst_n mid-run → pc returns to 0x100 asynchronously.
- jal at 0x100 with imme=0x40 → pred_taken=1, next pc=0x140.
- B_type at 0x200, imme=-8:
  - Cold BHT → predicted not-taken, next pc 0x204.
  - Two ex_br_valid taken updates for 0x200 → counter 11, next encounter predicts 0x1F8.
  - Three not-taken updates → counter 00; a further decrement stays at 00.
- jal Rd=1 at 0x300 pushes 0x304; later ret (jalr Rs1=1, Rd=0, imme=0) → pred_target=0x304.
- Five nested calls with RAS_DEPTH=4 → returns predict the four most recent addresses; the fifth return falls back to pc4 or is resolved by EX.
- Same-cycle events:
  - ex_redirect with ex_target=0x500 together with stall_if and a jal → pc=0x500, flush=1, RAS unchanged.
  - stall_if alone → pc held, RAS unchanged.
